// File: rtl/end_screen_renderer.sv
// End-of-game screen generator: centred title, score label and decimal score.
// Glyph rows are fetched from an external synchronous font ROM; pixel path is
// three registers deep (S0 layout/ROM address, S1 ROM wait, S2 bit select).
module end_screen_renderer #(
  parameter int          H_RES        = 640,
  parameter int          SCORE_W      = 14,
  parameter int          DIGITS       = 4,
  parameter int          SCALE_LOG2   = 0,
  parameter int          TITLE_Y      = 32,
  parameter int          LABEL_Y      = 112,
  parameter int          SCORE_Y      = 144,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] WIN_RGB      = 16'hFFE0,
  parameter logic [15:0] FG_RGB       = 16'hFFFF,
  parameter logic [15:0] BG_RGB       = 16'h0000
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic               frame_start,
  input  logic               game_over,
  input  logic               game_won,
  input  logic [SCORE_W-1:0] score,
  output logic [5:0]         glyph_code,
  output logic [3:0]         glyph_row,
  input  logic [7:0]         glyph_bits,
  output logic [15:0]        pix_data,
  output logic               busy
);

  localparam int          S        = SCALE_LOG2;
  localparam int          CW       = 8 << S;
  localparam int          CH       = 16 << S;
  localparam int          STAGES   = 1;
  localparam int          CNT_W    = $clog2(SCORE_W + 1);
  localparam logic [5:0]  SPACE    = 6'd26;
  localparam logic [31:0] CH32     = 32'(CH);
  localparam logic [31:0] WIN_W    = 32'(16 * CW);
  localparam logic [31:0] LOSE_W   = 32'(8 * CW);
  localparam logic [31:0] LABEL_W  = 32'(16 * CW);
  localparam logic [31:0] SCORE_WP = 32'(DIGITS * CW);
  localparam logic [31:0] WIN_X    = 32'((H_RES - 16 * CW) / 2);
  localparam logic [31:0] LOSE_X   = 32'((H_RES - 8 * CW) / 2);
  localparam logic [31:0] LABEL_X  = 32'((H_RES - 16 * CW) / 2);
  localparam logic [31:0] SCORE_X  = 32'((H_RES - DIGITS * CW) / 2);
  localparam logic [31:0] T_Y      = 32'(TITLE_Y);
  localparam logic [31:0] L_Y      = 32'(LABEL_Y);
  localparam logic [31:0] S_Y      = 32'(SCORE_Y);
  localparam logic [63:0] MAX_SC   = 64'(10 ** DIGITS - 1);
  localparam logic [15:0] BLINK_N  = 16'(BLINK_FRAMES);
  localparam logic [15:0] BLINK_MX = 16'(2 * BLINK_FRAMES - 1);

  // Strings, first character in the most significant slot.
  localparam logic [16*6-1:0] WIN_STR = {6'd21, 6'd8, 6'd2, 6'd19, 6'd14, 6'd17, 6'd24, 6'd26,
                                         6'd0, 6'd2, 6'd7, 6'd8, 6'd4, 6'd21, 6'd4, 6'd3};
  localparam logic [8*6-1:0]  LOSE_STR = {6'd24, 6'd14, 6'd20, 6'd26, 6'd3, 6'd8, 6'd4, 6'd3};
  localparam logic [16*6-1:0] LABEL_STR = {6'd24, 6'd14, 6'd20, 6'd17, 6'd26, 6'd5, 6'd8, 6'd13,
                                           6'd0, 6'd11, 6'd26, 6'd18, 6'd2, 6'd14, 6'd17, 6'd4};

  logic                         go_q, rise, won_l, sat, title_on;
  logic [SCORE_W-1:0]           sh;
  logic [CNT_W-1:0]             cnt;
  logic [DIGITS-1:0][3:0]       bcd, adj, disp;
  logic [DIGITS*4-1:0]          adj_flat;
  logic [DIGITS-1:0]            blank;
  logic [15:0]                  blink_cnt;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][2:0]         bit_pipe;
  logic [STAGES:0][15:0]        col_pipe;
  logic                         act_n;
  logic [5:0]                   code_n;
  logic [3:0]                   row_n;
  logic [2:0]                   bit_n;
  logic [15:0]                  col_n;
  logic [31:0]                  x, y, dx, dy, ci, d, title_x, title_w;

  assign rise = game_over & ~go_q;

  // Shift-add-3 adjust, one instance per decimal digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign adj[g] = (bcd[g] >= 4'd5) ? bcd[g] + 4'd3 : bcd[g];
  end
  assign adj_flat = adj;
  assign disp     = sat ? {DIGITS{4'd9}} : bcd;
  assign title_on = won_l || (BLINK_FRAMES == 0) || (blink_cnt < BLINK_N);

  // Leading-zero mask; the ones digit is never blanked so score 0 shows '0'.
  always_comb begin
    logic lz;
    blank = '0;
    lz    = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      blank[k] = lz && (disp[k] == 4'd0);
      lz       = blank[k];
    end
  end

  // Outcome capture and sequential binary-to-BCD conversion.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      go_q  <= 1'b0;
      busy  <= 1'b0;
      won_l <= 1'b0;
      sat   <= 1'b0;
      sh    <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      go_q <= game_over;
      if (!game_over) begin
        busy <= 1'b0;
      end else if (rise) begin
        sh    <= score;
        won_l <= game_won;
        sat   <= 64'(score) > MAX_SC;
        bcd   <= '0;
        cnt   <= CNT_W'(SCORE_W);
        busy  <= 1'b1;
      end else if (busy) begin
        sh  <= sh << 1;
        bcd <= {adj_flat[DIGITS*4-2:0], sh[SCORE_W-1]};
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) busy <= 1'b0;
      end
    end
  end

  // Blink frame counter; held at 0 off-screen and on the capture edge.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          blink_cnt <= '0;
    else if (!game_over || rise)             blink_cnt <= '0;
    else if (frame_start && BLINK_FRAMES > 0)
      blink_cnt <= (blink_cnt == BLINK_MX) ? '0 : blink_cnt + 16'd1;
  end

  // S0 layout decode: which line, which character, which glyph row/column.
  always_comb begin
    x       = {22'd0, pix_x};
    y       = {22'd0, pix_y};
    title_x = won_l ? WIN_X : LOSE_X;
    title_w = won_l ? WIN_W : LOSE_W;
    act_n   = 1'b0;
    code_n  = SPACE;
    row_n   = '0;
    bit_n   = '0;
    col_n   = BG_RGB;
    dx      = '0;
    dy      = '0;
    ci      = '0;
    d       = '0;
    if (game_over) begin
      if (y >= T_Y && y < T_Y + CH32 && x >= title_x && x < title_x + title_w) begin
        dx = x - title_x;
        dy = y - T_Y;
        ci = dx >> (3 + S);
        if (title_on) begin
          act_n  = 1'b1;
          col_n  = won_l ? WIN_RGB : FG_RGB;
          code_n = won_l ? WIN_STR[6*(15-ci) +: 6] : LOSE_STR[6*(7-ci) +: 6];
        end
      end else if (y >= L_Y && y < L_Y + CH32 && x >= LABEL_X && x < LABEL_X + LABEL_W) begin
        dx     = x - LABEL_X;
        dy     = y - L_Y;
        ci     = dx >> (3 + S);
        act_n  = 1'b1;
        col_n  = FG_RGB;
        code_n = LABEL_STR[6*(15-ci) +: 6];
      end else if (y >= S_Y && y < S_Y + CH32 && x >= SCORE_X && x < SCORE_X + SCORE_WP) begin
        dx     = x - SCORE_X;
        dy     = y - S_Y;
        ci     = dx >> (3 + S);
        d      = 32'(DIGITS - 1) - ci;
        act_n  = 1'b1;
        col_n  = FG_RGB;
        code_n = (busy || blank[d]) ? SPACE : 6'd27 + {2'b00, disp[d]};
      end
      if (act_n) begin
        row_n = 4'((dy >> S) & 32'd15);
        bit_n = 3'((dx >> S) & 32'd7);
      end
    end
  end

  // S0/S1/S2 pixel pipeline; line state rides alongside the ROM access.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      glyph_code <= SPACE;
      glyph_row  <= '0;
      vld_pipe   <= '0;
      bit_pipe   <= '0;
      col_pipe   <= '0;
      pix_data   <= BG_RGB;
    end else begin
      glyph_code  <= code_n;
      glyph_row   <= row_n;
      vld_pipe    <= {vld_pipe[STAGES-1:0], act_n};
      bit_pipe[0] <= bit_n;
      col_pipe[0] <= col_n;
      bit_pipe[1] <= bit_pipe[0];
      col_pipe[1] <= col_pipe[0];
      pix_data    <= (vld_pipe[STAGES] && glyph_bits[3'd7 - bit_pipe[1]]) ? col_pipe[1] : BG_RGB;
    end
  end

endmodule
